gamma_curve_loader: RTL and testbench
=====================================

Name: gamma_curve_loader

Overview:
- Upstream companion of the per-pixel gamma correction stage.
- Owns the 768-entry gamma LUT write port: {R curve 0..255, G curve 256..511, B curve 512..767}, 8-bit entries.
- After reset, fills an identity ramp. Then accepts new curves from the HPS config path as a byte stream with a valid/ready handshake.
- Gates the downstream gamma enable so correction is never applied to a partially written curve.

Parameters:
- ENTRIES, 768, total LUT entries (3 channels x 256).
- TIMEOUT_W, 20, width of the inter-byte timeout counter; timeout fires after 2^TIMEOUT_W-1 idle cycles in LOAD.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  single-cycle pulse: begin a new curve load at address 0.
- cfg_valid  in  1  cfg_data holds a curve byte.
- cfg_data  in  8  curve byte, sent in LUT address order.
- cfg_ready  out  1  loader accepts a byte this cycle.
- gamma_en_req  in  1  user/OSD gamma enable request.
- gamma_wr  out  1  LUT write strobe, one cycle per entry.
- gamma_wr_addr  out  10  LUT write address.
- gamma_value  out  8  LUT write data.
- gamma_en  out  1  qualified enable to the correction stage.
- busy  out  1  high in INIT or LOAD.
- curve_valid  out  1  a complete user curve is resident.
- load_err  out  1  sticky: last load timed out.

Behaviour:
- Reset values (async, reset_n low): state=INIT, addr=0, gamma_wr=0, gamma_wr_addr=0, gamma_value=0, cfg_ready=0, gamma_en=0, busy=1, curve_valid=0, load_err=0, timeout counter=0.
- State machine states: INIT, IDLE, LOAD.
- INIT:
  - One write per cycle: gamma_wr=1, gamma_wr_addr=addr, gamma_value=addr[7:0]. This is an identity ramp per channel.
  - addr increments each cycle.
  - After addr=ENTRIES-1 is written: state goes to IDLE, addr=0.
  - Duration is exactly 768 consecutive gamma_wr cycles.
  - cfg_ready=0. cfg_start is ignored.
- IDLE:
  - gamma_wr=0, cfg_ready=0. Bytes presented with cfg_valid are not consumed.
  - cfg_start leads to LOAD: addr=0, curve_valid cleared, load_err cleared, timeout counter cleared.
- LOAD:
  - cfg_ready=1, registered: it goes high the cycle after entering LOAD.
  - Accept: cfg_valid & cfg_ready. On the next cycle gamma_wr=1, gamma_wr_addr=addr, gamma_value=cfg_data. Latency is 1 cycle; addr then increments.
  - Back-to-back accepts are supported, one byte per cycle. Holes in cfg_valid are allowed.
  - The accept of the 768th byte (addr=ENTRIES-1) moves the state to IDLE. cfg_ready drops the same cycle its write strobe issues, curve_valid goes to 1, and addr=0.
  - cfg_start during LOAD restarts at addr=0. A byte accepted in that same cycle is discarded; cfg_start has priority.
  - Timeout counter clears on each accept and otherwise increments. At all-ones: load_err=1, curve_valid=0, state goes to INIT, which restores the identity ramp.
- gamma_en: registered. It equals gamma_en_req & curve_valid & (state==IDLE). It is 0 throughout INIT and LOAD and after a timeout.
- busy = (state!=IDLE), registered alongside the state.
- Address wrap: addr never exceeds ENTRIES-1. There is no write to 768..1023.
- Reset mid-load: everything returns to the reset values. INIT reruns and any partial curve is overwritten.

Decomposition:
- Package gamma_pkg:
  - GAMMA_ENTRIES=768.
  - Channel base constants R_BASE=0, G_BASE=256, B_BASE=512.
  - Typedef gamma_state_t {INIT, IDLE, LOAD}.
  - Typedef gamma_addr_t (10 bits).
- Single module; no sub-module is needed. The timeout counter is inline.

Test Plan:
- Reset then run 800 cycles -> exactly 768 gamma_wr pulses; addr 0..767 in order; value at addr 300 is 44 (300 mod 256); afterwards busy=0, curve_valid=0, gamma_en=0 even with gamma_en_req=1.
- cfg_start, then 768 back-to-back bytes of value (255-i[7:0]) -> 768 writes, each one cycle after its accept; addr 767 gets value 0; curve_valid=1; with gamma_en_req=1, gamma_en=1 one cycle after returning to IDLE.
- Load with cfg_valid toggling 1/0 each cycle, plus 5 extra bytes after completion -> still 768 writes total; extra bytes see cfg_ready=0 and produce no gamma_wr.
- cfg_start pulse after 100 accepted bytes, coinciding with a valid byte -> that byte is dropped; the next write is at addr 0; a full 768 then completes normally.
- Stall cfg_valid at byte 400 with TIMEOUT_W=4 -> after 15 idle cycles load_err=1, curve_valid=0, INIT rewrites the identity ramp over 768 cycles, gamma_en stays 0.
- Assert reset_n low at byte 500 of a load -> outputs go to reset values immediately; INIT restarts from addr 0.

Source files
------------

// File: rtl/gamma_pkg.sv
// ----------------------------------------------------------------------------
// gamma_pkg
//   Shared types and constants for the gamma LUT loader.
//   LUT layout: R curve at 0..255, G curve at 256..511, B curve at 512..767,
//   one 8-bit entry per address.
// ----------------------------------------------------------------------------
package gamma_pkg;

    typedef logic [9:0] gamma_addr_t;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        LOAD = 2'd2
    } gamma_state_t;

    localparam int          GAMMA_ENTRIES = 768;
    localparam gamma_addr_t R_BASE        = 10'd0;
    localparam gamma_addr_t G_BASE        = 10'd256;
    localparam gamma_addr_t B_BASE        = 10'd512;

    // Identity ramp value for a LUT address: offset inside its channel.
    function automatic logic [7:0] ramp_value(input gamma_addr_t a);
        gamma_addr_t off;
        if (a >= B_BASE) begin
            off = a - B_BASE;
        end else if (a >= G_BASE) begin
            off = a - G_BASE;
        end else begin
            off = a - R_BASE;
        end
        return off[7:0];
    endfunction

endpackage

// File: rtl/gamma_curve_loader.sv
// ----------------------------------------------------------------------------
// gamma_curve_loader
//   Owns the write port of the 768-entry gamma LUT. After reset it writes an
//   identity ramp into all three channel curves; afterwards it accepts a new
//   curve from the config path as a valid/ready byte stream and writes each
//   byte one cycle after it is accepted. The downstream gamma enable is only
//   passed through while a complete user curve is resident and no write
//   activity is in progress.
//
// Parameters
//   ENTRIES    total LUT entries (3 x 256)
//   TIMEOUT_W  inter-byte timeout counter width; a load is abandoned after
//              2^TIMEOUT_W-1 consecutive cycles without an accepted byte
//
// Ports
//   clk_sys        in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   cfg_start      in   pulse: begin a new curve load at address 0
//   cfg_valid      in   cfg_data holds a curve byte
//   cfg_data       in   curve byte, LUT address order
//   cfg_ready      out  byte accepted this cycle when cfg_valid is high
//   gamma_en_req   in   user/OSD gamma enable request
//   gamma_wr       out  LUT write strobe, one cycle per entry
//   gamma_wr_addr  out  LUT write address
//   gamma_value    out  LUT write data
//   gamma_en       out  qualified enable to the correction stage
//   busy           out  high while in INIT or LOAD
//   curve_valid    out  a complete user curve is resident
//   load_err       out  sticky: last load timed out
// ----------------------------------------------------------------------------
module gamma_curve_loader
    import gamma_pkg::*;
#(
    parameter int ENTRIES   = GAMMA_ENTRIES,
    parameter int TIMEOUT_W = 20
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       cfg_start,
    input  logic       cfg_valid,
    input  logic [7:0] cfg_data,
    output logic       cfg_ready,
    input  logic       gamma_en_req,
    output logic       gamma_wr,
    output logic [9:0] gamma_wr_addr,
    output logic [7:0] gamma_value,
    output logic       gamma_en,
    output logic       busy,
    output logic       curve_valid,
    output logic       load_err
);

    localparam gamma_addr_t LAST_ADDR = gamma_addr_t'(ENTRIES - 1);

    gamma_state_t         r_state;
    gamma_addr_t          r_addr;
    logic [TIMEOUT_W-1:0] r_tcnt;
    logic                 r_wr;
    gamma_addr_t          r_wr_addr;
    logic [7:0]           r_value;
    logic                 r_ready;
    logic                 r_en;
    logic                 r_busy;
    logic                 r_curve_valid;
    logic                 r_load_err;

    logic                 w_accept;
    logic                 w_last;
    logic [TIMEOUT_W-1:0] w_tcnt_inc;
    logic                 w_tcnt_sat;

    // r_ready is only ever high in LOAD, so it fully qualifies an accept.
    assign w_accept   = cfg_valid & r_ready;
    assign w_last     = (r_addr == LAST_ADDR);
    assign w_tcnt_inc = r_tcnt + TIMEOUT_W'(1);
    // Timeout fires on the idle cycle that would bring the counter to all-ones.
    assign w_tcnt_sat = &w_tcnt_inc;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= INIT;
            r_addr        <= '0;
            r_tcnt        <= '0;
            r_wr          <= 1'b0;
            r_wr_addr     <= '0;
            r_value       <= '0;
            r_ready       <= 1'b0;
            r_en          <= 1'b0;
            r_busy        <= 1'b1;
            r_curve_valid <= 1'b0;
            r_load_err    <= 1'b0;
        end else begin
            r_wr <= 1'b0;
            // Evaluated from the current state; a start in IDLE suppresses it
            // so the enable never leaks into the first LOAD cycle.
            r_en <= gamma_en_req & r_curve_valid & (r_state == IDLE) & ~cfg_start;

            case (r_state)
                INIT: begin
                    r_wr      <= 1'b1;
                    r_wr_addr <= r_addr;
                    r_value   <= ramp_value(r_addr);
                    if (w_last) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_addr  <= '0;
                    end else begin
                        r_addr <= r_addr + 10'd1;
                    end
                end

                IDLE: begin
                    if (cfg_start) begin
                        r_state       <= LOAD;
                        r_busy        <= 1'b1;
                        r_ready       <= 1'b1;
                        r_addr        <= '0;
                        r_tcnt        <= '0;
                        r_curve_valid <= 1'b0;
                        r_load_err    <= 1'b0;
                    end
                end

                LOAD: begin
                    if (cfg_start) begin
                        // Restart wins over a byte offered in the same cycle.
                        r_addr        <= '0;
                        r_tcnt        <= '0;
                        r_curve_valid <= 1'b0;
                        r_load_err    <= 1'b0;
                    end else if (w_accept) begin
                        r_wr      <= 1'b1;
                        r_wr_addr <= r_addr;
                        r_value   <= cfg_data;
                        r_tcnt    <= '0;
                        if (w_last) begin
                            r_state       <= IDLE;
                            r_busy        <= 1'b0;
                            r_ready       <= 1'b0;
                            r_curve_valid <= 1'b1;
                            r_addr        <= '0;
                        end else begin
                            r_addr <= r_addr + 10'd1;
                        end
                    end else if (w_tcnt_sat) begin
                        // Abandon the partial curve and restore the identity ramp.
                        r_state       <= INIT;
                        r_busy        <= 1'b1;
                        r_ready       <= 1'b0;
                        r_load_err    <= 1'b1;
                        r_curve_valid <= 1'b0;
                        r_addr        <= '0;
                        r_tcnt        <= '0;
                    end else begin
                        r_tcnt <= w_tcnt_inc;
                    end
                end

                default: begin
                    r_state <= INIT;
                    r_busy  <= 1'b1;
                    r_ready <= 1'b0;
                    r_addr  <= '0;
                end
            endcase
        end
    end

    assign cfg_ready     = r_ready;
    assign gamma_wr      = r_wr;
    assign gamma_wr_addr = r_wr_addr;
    assign gamma_value   = r_value;
    assign gamma_en      = r_en;
    assign busy          = r_busy;
    assign curve_valid   = r_curve_valid;
    assign load_err      = r_load_err;

endmodule

// File: tb/tb_gamma_curve_loader.sv
// ----------------------------------------------------------------------------
// tb_gamma_curve_loader
//   Bench for gamma_curve_loader with TIMEOUT_W=4. Every expected LUT write is
//   queued when its cause is driven (reset release, timeout, accepted byte)
//   and popped when the strobe appears. Load scenarios come from a table;
//   restart and reset-mid-load are written out by hand.
// ----------------------------------------------------------------------------
module tb_gamma_curve_loader;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       cfg_start;
    logic       cfg_valid;
    logic [7:0] cfg_data;
    logic       cfg_ready;
    logic       gamma_en_req;
    logic       gamma_wr;
    logic [9:0] gamma_wr_addr;
    logic [7:0] gamma_value;
    logic       gamma_en;
    logic       busy;
    logic       curve_valid;
    logic       load_err;

    gamma_curve_loader #(
        .ENTRIES   (768),
        .TIMEOUT_W (4)
    ) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .cfg_start     (cfg_start),
        .cfg_valid     (cfg_valid),
        .cfg_data      (cfg_data),
        .cfg_ready     (cfg_ready),
        .gamma_en_req  (gamma_en_req),
        .gamma_wr      (gamma_wr),
        .gamma_wr_addr (gamma_wr_addr),
        .gamma_value   (gamma_value),
        .gamma_en      (gamma_en),
        .busy          (busy),
        .curve_valid   (curve_valid),
        .load_err      (load_err)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int addr;
        int val;
        int cyc;
    } wr_exp_t;

    typedef struct {
        int         gap;
        int         extra;
        int         stall_at;
        logic [7:0] mask;
        logic       en_req;
        logic       exp_cv;
        logic       exp_err;
        logic       exp_en;
        int         exp_writes;
    } scen_t;

    wr_exp_t q[$];
    scen_t   tbl[4];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wr_count = 0;
    int val_300  = -1;

    // Reference model of the handshake side.
    logic m_ready   = 1'b0;
    int   m_addr    = 0;
    int   m_idle    = 0;
    logic m_err     = 1'b0;
    logic m_cv      = 1'b0;
    logic m_done    = 1'b0;
    logic m_timeout = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_init(input int first_cyc);
        for (int i = 0; i < 768; i++) begin
            q.push_back('{i, i % 256, first_cyc + i});
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        wr_exp_t e;
        @(posedge clk_sys);
        cyc++;
        #1;
        if (gamma_wr === 1'b1) begin
            wr_count++;
            if (gamma_wr_addr == 10'd300) val_300 = int'(gamma_value);
        end
        if (q.size() == 0) begin
            check("spurious_wr", gamma_wr, 1'b0);
        end else if (gamma_wr === 1'b1 || q[0].cyc <= cyc) begin
            e = q.pop_front();
            check("wr_strobe", gamma_wr, 1'b1);
            check("wr_addr", gamma_wr_addr, e.addr);
            check("wr_value", gamma_value, e.val);
            check("wr_cycle", cyc, e.cyc);
        end
    endtask

    // Drive one cycle of config inputs and advance the model with it.
    task automatic drive(input logic start, input logic valid, input logic [7:0] data);
        logic nr;
        cfg_start = start;
        cfg_valid = valid;
        cfg_data  = data;
        check("cfg_ready", cfg_ready, m_ready);
        nr = m_ready;
        if (start) begin
            m_addr    = 0;
            m_idle    = 0;
            m_err     = 1'b0;
            m_cv      = 1'b0;
            m_done    = 1'b0;
            m_timeout = 1'b0;
            nr        = 1'b1;
        end else if (m_ready) begin
            if (valid) begin
                q.push_back('{m_addr, int'(data), cyc + 1});
                m_idle = 0;
                if (m_addr == 767) begin
                    m_addr = 0;
                    nr     = 1'b0;
                    m_cv   = 1'b1;
                    m_done = 1'b1;
                end else begin
                    m_addr++;
                end
            end else begin
                m_idle++;
                if (m_idle == 15) begin
                    m_err     = 1'b1;
                    m_cv      = 1'b0;
                    m_timeout = 1'b1;
                    nr        = 1'b0;
                    push_init(cyc + 2);
                end
            end
        end
        tick();
        m_ready   = nr;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic send_bytes(input int n, input int gap, input logic [7:0] mask, input int stall_at);
        int         sent;
        int         guard;
        logic [7:0] d;
        sent  = 0;
        guard = 0;
        while (sent < n && !m_done && !m_timeout && guard < 5000) begin
            guard++;
            if (sent == stall_at) begin
                for (int k = 0; k < 40 && !m_timeout; k++) begin
                    drive(1'b0, 1'b0, 8'($urandom));
                    check("load_err_stall", load_err, m_err);
                end
            end else begin
                d = sent[7:0] ^ mask;
                drive(1'b0, 1'b1, d);
                sent++;
                if (!m_done) begin
                    for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 8'($urandom));
                end
            end
        end
        if (guard >= 5000) check("send_guard", guard, 0);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 2000 && q.size() != 0; k++) begin
            tick();
            check("en_off_init", gamma_en, 1'b0);
        end
        if (q.size() != 0) check("init_done", q.size(), 0);
    endtask

    task automatic check_reset_values();
        check("rst_wr", gamma_wr, 1'b0);
        check("rst_addr", gamma_wr_addr, 10'd0);
        check("rst_value", gamma_value, 8'd0);
        check("rst_ready", cfg_ready, 1'b0);
        check("rst_en", gamma_en, 1'b0);
        check("rst_busy", busy, 1'b1);
        check("rst_cv", curve_valid, 1'b0);
        check("rst_err", load_err, 1'b0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;

        tbl[0] = '{0, 0, -1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 768};
        tbl[1] = '{1, 5, -1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 768};
        tbl[2] = '{2, 0, -1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 768};
        tbl[3] = '{0, 0, 400, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 400 + 768};

        reset_n      = 1'b0;
        cfg_start    = 1'b0;
        cfg_valid    = 1'b0;
        cfg_data     = 8'h00;
        gamma_en_req = 1'b1;

        // Power-up: identity ramp, then idle with no curve.
        repeat (3) tick();
        check_reset_values();
        reset_n = 1'b1;
        push_init(cyc + 1);
        w0 = wr_count;
        repeat (800) tick();
        check("init_writes", wr_count - w0, 768);
        check("init_pending", q.size(), 0);
        check("init_val300", val_300, 44);
        check("init_busy", busy, 1'b0);
        check("init_cv", curve_valid, 1'b0);
        check("init_en", gamma_en, 1'b0);

        // Table-driven loads.
        for (int s = 0; s < 4; s++) begin
            gamma_en_req = tbl[s].en_req;
            w0 = wr_count;
            drive(1'b1, 1'b0, 8'h00);
            send_bytes(768, tbl[s].gap, tbl[s].mask, tbl[s].stall_at);
            if (m_timeout) begin
                wait_idle();
                tick();
                check("to_en", gamma_en, tbl[s].exp_en);
            end else begin
                check("done_en_first", gamma_en, 1'b0);
                drive(1'b0, 1'b0, 8'h00);
                check("done_en", gamma_en, tbl[s].exp_en);
                for (int k = 0; k < tbl[s].extra; k++) drive(1'b0, 1'b1, 8'($urandom));
                tick();
            end
            check("scen_busy", busy, 1'b0);
            check("scen_cv", curve_valid, tbl[s].exp_cv);
            check("scen_err", load_err, tbl[s].exp_err);
            check("scen_writes", wr_count - w0, tbl[s].exp_writes);
            check("scen_pending", q.size(), 0);
        end

        // Restart after 100 bytes; the byte sent with cfg_start is dropped.
        gamma_en_req = 1'b1;
        w0 = wr_count;
        drive(1'b1, 1'b0, 8'h00);
        send_bytes(100, 0, 8'hC3, -1);
        drive(1'b1, 1'b1, 8'hAA);
        send_bytes(768, 0, 8'h96, -1);
        check("rs_en_first", gamma_en, 1'b0);
        tick();
        check("rs_en", gamma_en, 1'b1);
        check("rs_cv", curve_valid, 1'b1);
        check("rs_err", load_err, 1'b0);
        check("rs_writes", wr_count - w0, 868);
        check("rs_pending", q.size(), 0);

        // Reset asserted in the middle of a load.
        drive(1'b1, 1'b0, 8'h00);
        send_bytes(500, 0, 8'h0F, -1);
        reset_n = 1'b0;
        #1;
        check_reset_values();
        q.delete();
        m_ready   = 1'b0;
        m_cv      = 1'b0;
        m_err     = 1'b0;
        m_done    = 1'b0;
        m_timeout = 1'b0;
        repeat (3) tick();
        check_reset_values();
        reset_n = 1'b1;
        push_init(cyc + 1);
        w0 = wr_count;
        wait_idle();
        tick();
        check("rml_writes", wr_count - w0, 768);
        check("rml_busy", busy, 1'b0);
        check("rml_cv", curve_valid, 1'b0);
        check("rml_en", gamma_en, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
